// File: rtl/seg_capture.sv
// Decodes a multiplexed active-low 7-seg/anode bus back into a 16-bit value with presence/invalid masks; capture 1+STABLE_CYCLES after pin change, frame_valid 1 cycle after close.
// No backpressure: results are published as pulses. Define SEG_CAPTURE_SYNC_EN to add a two-flop synchronizer ahead of the sample register.
module seg_capture #(
  parameter int unsigned STABLE_CYCLES  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic        dp,
  input  logic [3:0]  an,
  output logic [15:0] num,
  output logic [3:0]  present,
  output logic [3:0]  invalid,
  output logic        frame_valid,
  output logic        collision
);

  localparam logic [7:0]  STABLE_C  = 8'(STABLE_CYCLES);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT_CYCLES);
  localparam logic [11:0] IDLE_PINS = 12'hFFF;

  logic [11:0] pin_w;

`ifdef SEG_CAPTURE_SYNC_EN
  logic [11:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= IDLE_PINS;
      sync2_q <= IDLE_PINS;
    end else begin
      sync1_q <= {an, dp, seg};
      sync2_q <= sync1_q;
    end
  end

  assign pin_w = sync2_q;
`else
  assign pin_w = {an, dp, seg};
`endif

  // Sample register: {an[3:0], dp, seg[6:0]}, idles as a blank slot.
  logic [11:0] samp_q, prev_q;
  logic        prev_act_q;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic        done_q, done_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [15:0] acc_num_q, acc_num_d;
  logic [3:0]  acc_pres_q, acc_pres_d;
  logic [3:0]  acc_inv_q, acc_inv_d;
  logic [15:0] num_q, num_d;
  logic [3:0]  present_q, present_d;
  logic [3:0]  invalid_q, invalid_d;
  logic        fv_q, fv_d;
  logic        coll_q;

  logic [3:0]  an_s;
  logic [6:0]  seg_s;
  logic        dp_s;
  logic        act_w, blank_w, coll_w;
  logic [1:0]  idx_w;
  logic        same_w, done_prev_w, capture_w;
  logic [7:0]  cnt_inc_w;
  logic [4:0]  dec_w;
  logic        inv_w;
  logic [3:0]  nib_w;
  logic [3:0]  lane_w;

  assign an_s  = samp_q[11:8];
  assign dp_s  = samp_q[7];
  assign seg_s = samp_q[6:0];

  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    r = 5'h10;
    case (s)
      7'h40: r = 5'h00;
      7'h79: r = 5'h01;
      7'h24: r = 5'h02;
      7'h30: r = 5'h03;
      7'h19: r = 5'h04;
      7'h12: r = 5'h05;
      7'h02: r = 5'h06;
      7'h78: r = 5'h07;
      7'h00: r = 5'h08;
      7'h10: r = 5'h09;
      7'h08: r = 5'h0A;
      7'h03: r = 5'h0B;
      7'h46: r = 5'h0C;
      7'h21: r = 5'h0D;
      7'h06: r = 5'h0E;
      7'h0E: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    act_w = 1'b0;
    idx_w = 2'd0;
    case (an_s)
      4'b1110: begin act_w = 1'b1; idx_w = 2'd0; end
      4'b1101: begin act_w = 1'b1; idx_w = 2'd1; end
      4'b1011: begin act_w = 1'b1; idx_w = 2'd2; end
      4'b0111: begin act_w = 1'b1; idx_w = 2'd3; end
      default: begin act_w = 1'b0; idx_w = 2'd0; end
    endcase
  end

  assign blank_w = (an_s == 4'hF);
  assign coll_w  = !act_w && !blank_w;

  // One capture per contiguous activation: done_q latches until the sample changes.
  assign same_w      = act_w && prev_act_q && (samp_q == prev_q);
  assign cnt_inc_w   = (stab_cnt_q >= STABLE_C) ? STABLE_C : stab_cnt_q + 8'd1;
  assign stab_cnt_d  = !act_w ? 8'd0 : (same_w ? cnt_inc_w : 8'd1);
  assign done_prev_w = same_w && done_q;
  assign capture_w   = act_w && (stab_cnt_d == STABLE_C) && !done_prev_w;
  assign done_d      = act_w && (done_prev_w || capture_w);

  assign dec_w  = decode(seg_s);
  assign inv_w  = dec_w[4] || !dp_s;
  assign nib_w  = inv_w ? 4'h0 : dec_w[3:0];
  assign lane_w = 4'b0001 << idx_w;

  always_comb begin
    acc_num_d  = acc_num_q;
    acc_pres_d = acc_pres_q;
    acc_inv_d  = acc_inv_q;
    num_d      = num_q;
    present_d  = present_q;
    invalid_d  = invalid_q;
    fv_d       = 1'b0;
    to_cnt_d   = to_cnt_q;
    if (capture_w) begin
      to_cnt_d = 16'd1;
      if ((acc_pres_q & lane_w) != 4'h0) begin
        num_d      = acc_num_q;
        present_d  = acc_pres_q;
        invalid_d  = acc_inv_q;
        fv_d       = 1'b1;
        acc_num_d  = 16'h0000;
        acc_pres_d = 4'h0;
        acc_inv_d  = 4'h0;
      end
      acc_num_d[{idx_w, 2'b00} +: 4] = nib_w;
      acc_pres_d = acc_pres_d | lane_w;
      acc_inv_d  = inv_w ? (acc_inv_d | lane_w) : (acc_inv_d & ~lane_w);
    end else begin
      if (to_cnt_q != TIMEOUT_C) begin
        to_cnt_d = to_cnt_q + 16'd1;
      end
      // to_cnt_q holds cycles elapsed since the capture, so T-1 here puts frame_valid T cycles after it.
      if ((to_cnt_q == TIMEOUT_C - 16'd1) && (acc_pres_q != 4'h0)) begin
        num_d      = acc_num_q;
        present_d  = acc_pres_q;
        invalid_d  = acc_inv_q;
        fv_d       = 1'b1;
        acc_num_d  = 16'h0000;
        acc_pres_d = 4'h0;
        acc_inv_d  = 4'h0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q     <= IDLE_PINS;
      prev_q     <= IDLE_PINS;
      prev_act_q <= 1'b0;
      stab_cnt_q <= 8'd0;
      done_q     <= 1'b0;
      to_cnt_q   <= 16'd0;
      acc_num_q  <= 16'h0000;
      acc_pres_q <= 4'h0;
      acc_inv_q  <= 4'h0;
      num_q      <= 16'h0000;
      present_q  <= 4'h0;
      invalid_q  <= 4'h0;
      fv_q       <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      samp_q     <= pin_w;
      prev_q     <= samp_q;
      prev_act_q <= act_w;
      stab_cnt_q <= stab_cnt_d;
      done_q     <= done_d;
      to_cnt_q   <= to_cnt_d;
      acc_num_q  <= acc_num_d;
      acc_pres_q <= acc_pres_d;
      acc_inv_q  <= acc_inv_d;
      num_q      <= num_d;
      present_q  <= present_d;
      invalid_q  <= invalid_d;
      fv_q       <= fv_d;
      coll_q     <= coll_w;
    end
  end

  assign num         = num_q;
  assign present     = present_q;
  assign invalid     = invalid_q;
  assign frame_valid = fv_q;
  assign collision   = coll_q;

endmodule
